// File: rtl/posit_encoder_rne.sv
// Bit-serial posit<N,ES> encoder with round-to-nearest-even, regime saturation,
// zero/NaR special cases and two's-complement negation of the final result.
module posit_encoder_rne #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int FW = 32,
    parameter int KW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sign_in,
    input  logic          zero_in,
    input  logic          nar_in,
    input  logic [KW-1:0] k_in,
    input  logic [ES-1:0] exp_in,
    input  logic [FW-1:0] frac_in,
    output logic [N-1:0]  p_out,
    output logic          busy,
    output logic          done
);

    localparam int SW = ES + FW;
    localparam int CW = $clog2(N);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        ROUND,
        FIN
    } state_t;

    state_t        state;
    logic          sign_q;
    logic          zero_q;
    logic          nar_q;
    logic [KW-1:0] k_q;
    logic [SW-1:0] s_q;
    logic [KW-1:0] run_cnt;
    logic          run_bit;
    logic          term_pend;
    logic [CW-1:0] cnt;
    logic [N-2:0]  mag;
    logic [N-1:0]  p_q;

    int            k_int;
    logic [KW-1:0] run_len;
    logic          next_bit;
    logic          guard;
    logic          sticky;
    logic          inc;
    logic [N-1:0]  mag_inc;
    logic [N-2:0]  mag_rnd;
    logic [N-1:0]  p_next;
    logic          accept;

    // Regime clamp: beyond +-(N-2) the regime alone would overflow the N-1 magnitude bits.
    always_comb begin
        k_int = int'($signed(k_q));
        if (k_int > N - 2)
            k_int = N - 2;
        else if (k_int < -(N - 2))
            k_int = -(N - 2);
        run_len = (k_int >= 0) ? KW'(k_int + 1) : KW'(-k_int);
    end

    // Stream order: regime run, terminator, then S MSB-first with zero fill.
    always_comb begin
        next_bit = 1'b0;
        if (run_cnt != '0)
            next_bit = run_bit;
        else if (term_pend)
            next_bit = ~run_bit;
        else
            next_bit = s_q[SW-1];
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        guard  = 1'b0;
        sticky = 1'b0;
        if (run_cnt == '0 && !term_pend) begin
            guard  = s_q[SW-1];
            sticky = |s_q[SW-2:0];
        end
        inc     = guard & (mag[0] | sticky);
        mag_inc = {1'b0, mag} + N'(inc);
        mag_rnd = mag_inc[N-1] ? '1 : mag_inc[N-2:0];
        p_next  = sign_q ? (~{1'b0, mag_rnd} + N'(1)) : {1'b0, mag_rnd};
    end

    // A new request lands in IDLE, or in FIN on the edge where done rises.
    assign accept = start && ((state == IDLE && !done) || state == FIN);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
    // only control outputs are reset, datapath registers are always loaded before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p_out <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: ;
                LOAD: begin
                    if (nar_q) begin
                        p_q   <= NAR;
                        state <= FIN;
                    end else if (zero_q) begin
                        p_q   <= '0;
                        state <= FIN;
                    end else begin
                        run_cnt   <= run_len;
                        run_bit   <= (k_int >= 0);
                        term_pend <= 1'b1;
                        cnt       <= CW'(N - 1);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    mag <= {mag[N-3:0], next_bit};
                    if (run_cnt != '0)
                        run_cnt <= run_cnt - KW'(1);
                    else if (term_pend)
                        term_pend <= 1'b0;
                    else
                        s_q <= {s_q[SW-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= ROUND;
                end
                // Rounding and negation share one cycle so done lands N+2 edges after start.
                ROUND: begin
                    p_q   <= p_next;
                    state <= FIN;
                end
                FIN: begin
                    p_out <= p_q;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                sign_q <= sign_in;
                zero_q <= zero_in;
                nar_q  <= nar_in;
                k_q    <= k_in;
                s_q    <= {exp_in, frac_in};
                busy   <= 1'b1;
                state  <= LOAD;
            end
        end
    end

endmodule

// File: tb/tb_posit_encoder_rne.sv
// Scoreboard bench for posit_encoder_rne: directed vectors push expected posit and
// completion cycle; a monitor pops on every done pulse and compares.
module tb_posit_encoder_rne;

    localparam int N  = 32;
    localparam int ES = 2;
    localparam int FW = 32;
    localparam int KW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sign_in = 1'b0;
    logic          zero_in = 1'b0;
    logic          nar_in = 1'b0;
    logic [KW-1:0] k_in = '0;
    logic [ES-1:0] exp_in = '0;
    logic [FW-1:0] frac_in = '0;
    logic [N-1:0]  p_out;
    logic          busy;
    logic          done;

    typedef struct {
        string       name;
        logic [31:0] p;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    posit_encoder_rne #(.N(N), .ES(ES), .FW(FW), .KW(KW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sign_in (sign_in),
        .zero_in (zero_in),
        .nar_in  (nar_in),
        .k_in    (k_in),
        .exp_in  (exp_in),
        .frac_in (frac_in),
        .p_out   (p_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_p"}, 64'(p_out), 64'(e.p));
                check({e.name, "_lat"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic drive(input bit s, input bit z, input bit n, input int k,
                         input int e, input logic [31:0] f);
        sign_in = s;
        zero_in = z;
        nar_in  = n;
        k_in    = KW'(k);
        exp_in  = ES'(e);
        frac_in = f;
    endtask

    task automatic issue(input string name, input bit s, input bit z, input bit n,
                         input int k, input int e, input logic [31:0] f,
                         input logic [31:0] expp, input int lat);
        exp_t x;
        @(negedge clk);
        drive(s, z, n, k, e, f);
        start = 1'b1;
        x.name = name;
        x.p    = expp;
        x.due  = cyc + 1 + lat;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs after capture; the encode must not see them.
        drive(~s, 1'b0, 1'b0, 7, 1, 32'hDEAD_BEEF);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input string name, input bit s, input bit z, input bit n,
                       input int k, input int e, input logic [31:0] f,
                       input logic [31:0] expp, input int lat);
        issue(name, s, z, n, k, e, f, expp, lat);
        drain();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_p_out", 64'(p_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run("k0_pos",      0, 0, 0,   0, 0, 32'h0000_0000, 32'h4000_0000, 34);
        run("k0_neg",      1, 0, 0,   0, 0, 32'h0000_0000, 32'hC000_0000, 34);
        run("km1_e3",      0, 0, 0,  -1, 3, 32'h8000_0000, 32'h3C00_0000, 34);
        run("round_up",    0, 0, 0,   0, 0, 32'hFFFF_FFFF, 32'h4800_0000, 34);
        run("tie_even",    0, 0, 0,   0, 0, 32'h0000_0010, 32'h4000_0000, 34);
        run("tie_odd",     0, 0, 0,   0, 0, 32'h0000_0030, 32'h4000_0002, 34);
        run("tie_odd_neg", 1, 0, 0,   0, 0, 32'h0000_0030, 32'hBFFF_FFFE, 34);
        run("k30_max",     0, 0, 0,  30, 3, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34);
        run("k31_clamp",   0, 0, 0,  31, 0, 32'h0000_0000, 32'h7FFF_FFFF, 34);
        run("km31_clamp",  0, 0, 0, -31, 0, 32'h0000_0000, 32'h0000_0001, 34);
        run("km31_neg",    1, 0, 0, -31, 0, 32'h0000_0000, 32'hFFFF_FFFF, 34);
        run("km30_round",  0, 0, 0, -30, 3, 32'h0000_0000, 32'h0000_0002, 34);
        run("zero",        0, 1, 0,   5, 2, 32'h1234_5678, 32'h0000_0000, 2);
        run("nar_zero",    1, 1, 1,   5, 2, 32'h1234_5678, 32'h8000_0000, 2);

        // Start pulses while busy are dropped: exactly one done expected.
        issue("busy_ign", 0, 0, 0, 0, 0, 32'h0000_0000, 32'h4000_0000, 34);
        check("busy_high", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, -3, 2, 32'hA5A5_A5A5);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        drain();
        repeat (40) @(negedge clk);
        check("busy_idle", 64'(busy), 64'd0);

        // Reset mid-encode discards the operation without a done.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 2, 1, 32'h0F0F_0F0F);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_p_out", 64'(p_out), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (45) @(negedge clk);

        run("after_rst", 0, 0, 0, -1, 3, 32'h8000_0000, 32'h3C00_0000, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1);
    end

endmodule
